// File: rtl/window_3x3.sv
// 3x3 sliding window generator over a raster-order pixel stream.
// Two line buffers feed a 3x3 shift window; interior windows are
// emitted with a valid/ready handshake and centre coordinates.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   pixel input handshake, in_data raster order
//   out_valid/out_ready window output handshake
//   p0..p8              window pixels, row-major, p4 is the centre
//   out_row/out_col     centre pixel coordinates
//   out_last            last window of the frame
module window_3x3 #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              out_last
);

    localparam int         AW     = $clog2(IMG_W);
    localparam logic [7:0] C_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] R_LAST = 8'(IMG_H - 1);

    // Position of the next pixel to be accepted.
    logic [7:0] c;
    logic [7:0] r;

    // lb1 holds row r-1, lb2 holds row r-2 (no reset needed:
    // rows 0 and 1 of each frame refill them before any window uses them).
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];

    logic [DATA_W-1:0] win [3][3];

    logic          accept;
    logic          emit;
    logic [AW-1:0] ca;

    assign ca       = c[AW-1:0];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && (r >= 8'd2) && (c >= 8'd2);

    assign p0 = win[0][0];
    assign p1 = win[0][1];
    assign p2 = win[0][2];
    assign p3 = win[1][0];
    assign p4 = win[1][1];
    assign p5 = win[1][2];
    assign p6 = win[2][0];
    assign p7 = win[2][1];
    assign p8 = win[2][2];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[ca] <= in_data;
            lb2[ca] <= lb1[ca];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= 8'd0;
            r         <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= 8'd0;
            out_col   <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2[ca];
                win[1][2] <= lb1[ca];
                win[2][2] <= in_data;

                if (c == C_LAST) begin
                    c <= 8'd0;
                    r <= (r == R_LAST) ? 8'd0 : r + 8'd1;
                end else begin
                    c <= c + 8'd1;
                end
            end

            // A stall blocks accepts, so the window and tags stay frozen
            // until the consumer takes it.
            if (emit) begin
                out_valid <= 1'b1;
                out_row   <= r - 8'd1;
                out_col   <= c - 8'd1;
                out_last  <= (r == R_LAST) && (c == C_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_3x3.sv
// Randomised self-checking bench for window_3x3.
// Scoreboard built from a full frame image array.
module tb_window_3x3;

    localparam int W = 64;
    localparam int H = 64;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] in_data;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic [7:0] out_row, out_col;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
    logic [7:0] s_in_data;
    logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7, s8;
    logic [7:0] s_row, s_col;

    window_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
        .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    window_3x3 #(.IMG_W(5), .IMG_H(4), .DATA_W(8)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .p0(s0), .p1(s1), .p2(s2), .p3(s3), .p4(s4),
        .p5(s5), .p6(s6), .p7(s7), .p8(s8),
        .out_row(s_row), .out_col(s_col), .out_last(s_out_last)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [71:0] px;
        logic [7:0]  row;
        logic [7:0]  col;
        logic        last;
    } win_t;

    win_t        expq[$];
    logic [7:0]  img [H][W];
    int          mr, mc, wc, lc;
    bit          ramp, held;
    logic [71:0] hpx;
    logic [16:0] hpos;

    function automatic logic [71:0] dut_px();
        return {p0, p1, p2, p3, p4, p5, p6, p7, p8};
    endfunction

    task automatic model_accept(input logic [7:0] d);
        win_t e;
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2) begin
            e.px = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.px = {e.px[63:0], img[mr-2+i][mc-2+j]};
            e.row  = 8'(mr - 1);
            e.col  = 8'(mc - 1);
            e.last = (mr == H - 1) && (mc == W - 1);
            expq.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic cycle(input bit v, input bit rdy);
        win_t       e;
        logic [7:0] d;
        @(negedge clk);
        d         = ramp ? 8'((mr * W + mc) % 256) : 8'($urandom);
        in_valid  = v;
        out_ready = rdy;
        in_data   = v ? d : 8'($urandom);
        #1;
        check("in_ready", in_ready, !out_valid || out_ready);
        if (held) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_px", dut_px(), hpx);
            check("hold_pos", {out_row, out_col, out_last}, hpos);
        end
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("spurious", out_valid, 1'b0);
            end else begin
                e = expq.pop_front();
                check("win_px", dut_px(), e.px);
                check("win_row", out_row, e.row);
                check("win_col", out_col, e.col);
                check("win_last", out_last, e.last);
                wc++;
                if (ramp && e.row == 1 && e.col == 1) begin
                    check("first_px", dut_px(), 72'h000102_404142_808182);
                    check("first_lat", mr * W + mc, 131);
                end
                if (ramp && e.row == 62 && e.col == 62) begin
                    check("last_p0", p0, 8'd125);
                    check("last_p4", p4, 8'd190);
                    check("last_p8", p8, 8'd255);
                    check("last_flag", out_last, 1'b1);
                end
                if (e.last) begin
                    check("frame_cnt", wc, 3844);
                    wc = 0;
                    lc++;
                end
            end
        end
        held = out_valid && !out_ready;
        if (held) begin
            hpx  = dut_px();
            hpos = {out_row, out_col, out_last};
        end
        if (v && in_ready) model_accept(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'($urandom);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_px", dut_px(), 72'd0);
        check("rst_pos", {out_row, out_col, out_last}, 17'd0);
        check("post_rst_ready", in_ready, 1'b1);
        expq.delete();
        mr   = 0;
        mc   = 0;
        wc   = 0;
        held = 1'b0;
    endtask

    // mode 0: continuous, 1: continuous with a 10-cycle stall, 2: random
    task automatic run_frames(input int n, input int mode);
        int target;
        int k;
        int budget;
        target = lc + n;
        k      = 0;
        budget = (mode == 2) ? 50000 : 10000;
        while (lc < target && k < budget) begin
            bit v;
            bit rd;
            v  = 1'b1;
            rd = 1'b1;
            if (mode == 2) begin
                v  = 1'($urandom_range(0, 1));
                rd = 1'($urandom_range(0, 1));
            end
            if (mode == 1 && k >= 1000 && k < 1010) rd = 1'b0;
            cycle(v, rd);
            k++;
        end
        check("frame_timeout", lc, target);
        if (mode == 0) check("frame_cycles", k, W * H + 1);
        if (mode == 1) check("stall_cycles", k, W * H + 11);
    endtask

    task automatic small_test();
        int          sr, sc, got, idx, er, ec;
        logic [71:0] ep;
        sr  = 0;
        sc  = 0;
        got = 0;
        for (int k = 0; k < 60 && got < 12; k++) begin
            @(negedge clk);
            s_in_valid  = 1'b1;
            s_out_ready = 1'b1;
            s_in_data   = 8'(sr * 5 + sc);
            #1;
            check("s_in_ready", s_in_ready, 1'b1);
            if (s_out_valid) begin
                idx = got % 6;
                er  = 1 + idx / 3;
                ec  = 1 + idx % 3;
                ep  = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ep = {ep[63:0], 8'((er - 1 + i) * 5 + ec - 1 + j)};
                check("s_px", {s0, s1, s2, s3, s4, s5, s6, s7, s8}, ep);
                check("s_pos", {s_row, s_col}, {8'(er), 8'(ec)});
                check("s_last", s_out_last, (er == 2 && ec == 3));
                got++;
            end
            sc++;
            if (sc == 5) begin
                sc = 0;
                sr++;
                if (sr == 4) sr = 0;
            end
        end
        check("s_windows", got, 12);
        s_in_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_data   = 8'd0;
        s_out_ready = 1'b1;
        mr = 0; mc = 0; wc = 0; lc = 0;
        ramp = 1'b1;
        held = 1'b0;
        repeat (2) @(posedge clk);

        do_reset();
        run_frames(1, 1);

        do_reset();
        for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b1);
        do_reset();
        run_frames(1, 0);

        do_reset();
        ramp = 1'b0;
        run_frames(2, 2);

        do_reset();
        small_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 Parameter IMG_W, default 64, image width in pixels (columns, n); legal range 3..256.
REQ-002 Parameter IMG_H, default 64, image height in pixels (rows, m); legal range 3..256.
REQ-003 Parameter DATA_W, default 8, pixel width in bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_data holds a valid pixel.
REQ-007 in_data  input  DATA_W  pixel, raster order (row-major, row 0 first, column 0 first).
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  p0..p8 hold a valid 3x3 window.
REQ-010 out_ready  input  1  downstream (sobel kernel) consumes the window this cycle.
REQ-011 p0..p8  output  DATA_W each  window pixels, row-major: p0 top-left, p4 centre, p8 bottom-right.
REQ-012 out_row, out_col  output  8 each  centre pixel coordinates of the current window.
REQ-013 out_last  output  1  current window is the last of the frame.

Function
REQ-014 Pixel accepted on any cycle with in_valid=1 and in_ready=1; in_ready = !out_valid || out_ready (combinational).
REQ-015 Column counter c and row counter r track the next accepted pixel; c increments per accept, wraps IMG_W-1 -> 0 and increments r; r wraps IMG_H-1 -> 0 (next frame starts with no extra cycles).
REQ-016 Two line buffers of IMG_W x DATA_W hold rows r-1 and r-2; each accept writes in_data into row r-1 buffer at column c and shifts the old value to the row r-2 buffer at column c.
REQ-017 A 3x3 register window shifts left one column per accept; new right column = {row r-2 buf[c], row r-1 buf[c], in_data}.
REQ-018 Accepting pixel (r,c) with r>=2 and c>=2 SHALL set out_valid=1 on the next cycle with p0..p8 = pixels (r-2..r, c-2..c), out_row=r-1, out_col=c-1.
REQ-019 Accepts with r<2 or c<2 update buffers/counters only; no window issued (border centres never emitted).
REQ-020 Exactly (IMG_W-2)*(IMG_H-2) windows per frame (3844 at defaults), centres (1..IMG_H-2, 1..IMG_W-2) in raster order.
REQ-021 Latency: 1 cycle from accept of the window's p8 pixel to out_valid=1.
REQ-022 While out_valid=1 and out_ready=0, p0..p8, out_row, out_col, out_last SHALL hold stable and in_ready=0.
REQ-023 out_valid=1 and out_ready=1 with a simultaneous window-producing accept: new window loaded next cycle, out_valid stays 1 (full throughput, one window/cycle).
REQ-024 out_valid=1 and out_ready=1 with no window-producing accept: out_valid=0 next cycle.
REQ-025 out_last=1 only with the window centred at (IMG_H-2, IMG_W-2).
REQ-026 in_data is ignored on cycles without an accept; no buffer or counter change.
REQ-027 Line buffer contents need no reset; rows 0 and 1 of every frame overwrite them before use.

Reset
REQ-028 rst=1 at a rising edge SHALL set r=0, c=0, out_valid=0, out_last=0, p0..p8=0, out_row=0, out_col=0, regardless of in_valid/out_ready.
REQ-029 rst mid-frame SHALL abandon the partial frame; first accept after rst deasserts is pixel (0,0) of a new frame.
REQ-030 in_ready SHALL be 1 during and immediately after reset (out_valid=0).

Verification
REQ-031 Ramp 64x64 frame, pixel = (r*64+c) mod 256, out_ready=1, in_valid=1 continuous -> first window one cycle after 131st accept: p0..p8 = 0,1,2,64,65,66,128,129,130, out_row=1, out_col=1.
REQ-032 Same frame -> exactly 3844 windows; last has out_last=1, out_row=62, out_col=62, p0=125, p4=190, p8=255.
REQ-033 out_ready held 0 for 10 cycles mid-frame -> in_ready=0, outputs frozen for 10 cycles, no window lost or duplicated versus golden sequence.
REQ-034 Random in_valid (50%) and out_ready (50%) over two back-to-back frames -> window stream matches golden model, 3844 per frame, out_last once per frame.
REQ-035 rst asserted for one cycle after 1000 accepts, then full ramp frame -> out_valid=0 the cycle after rst, subsequent output identical to REQ-031/032.
REQ-036 IMG_W=5, IMG_H=4 -> 6 windows, centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3); wrap of c and r checked.
